regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised general-purpose register file for the core. Successor to the fixed 16x16 two-read-port register file.
- Single-edge clocking and synchronous reset.
- N combinational read ports, separate ALU and memory-load write ports, and a dedicated store-data read port.
- Per-register busy scoreboard tracking outstanding memory loads, so the control unit can stall on RAW/WAW hazards.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of architectural registers (2..64)
- IDX_W, $clog2(NUM_REGS), register index width
- NUM_RD, 2, number of ALU read ports (1..4)
- ZERO_REG, 1, when 1 register 0 is hardwired to zero

Ports:
- clk  in  1  core clock, all state updates on rising edge only
- rst  in  1  synchronous active-high reset
- rd_idx  in  NUM_RD*IDX_W  packed read indices, port k at bits [k*IDX_W +: IDX_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, same packing
- rd_busy  out  NUM_RD  busy bit of the register addressed by each read port
- alu_we  in  1  ALU writeback enable
- alu_idx  in  IDX_W  ALU destination index
- alu_data  in  DATA_W  ALU result
- mem_we  in  1  memory-load writeback enable
- mem_idx  in  IDX_W  load destination index
- mem_data  in  DATA_W  loaded data
- st_idx  in  IDX_W  store source index
- st_data  out  DATA_W  store source data (zero-reg rule applies)
- ld_issue  in  1  request to mark a load destination pending
- ld_issue_idx  in  IDX_W  load destination being issued
- ld_issue_ok  out  1  issue accepted this cycle (combinational)
- busy_vec  out  NUM_REGS  full scoreboard

Behaviour:
- Reset (rst=1 at posedge): all registers become 0 and busy_vec becomes 0. Reset overrides any same-cycle write or issue.
- Reads (rd_data, st_data, rd_busy) are combinational from current state, with zero latency.
- Writes take effect at the posedge where the enable is high and are visible to reads from the next cycle.
- Write collision (alu_we && mem_we && alu_idx==mem_idx): mem_data wins and the ALU write is dropped.
- ZERO_REG=1:
  - Index 0 always reads 0.
  - Writes to index 0 are ignored.
  - busy_vec[0] is always 0.
  - ld_issue to index 0 returns ld_issue_ok=1 but sets nothing.
- Index >= NUM_REGS (non-power-of-2 NUM_REGS): reads return 0 and busy 0; writes and issues are ignored; ld_issue_ok=0.
- Scoreboard:
  - ld_issue_ok = ld_issue && !busy_vec[ld_issue_idx] && !rst.
  - An accepted issue sets busy[ld_issue_idx] at the posedge.
  - mem_we clears busy[mem_idx] at the posedge.
  - alu_we does not touch busy. An ALU write to a busy register is performed, and the later load overwrites it; the control unit is responsible for stalling.
  - Same-cycle issue to idx A and mem_we to idx B, A != B: both take effect.
  - Same-cycle issue and mem_we to the same idx: the issue is rejected because the register is currently busy. The clear takes effect, so busy=0 next cycle.
  - mem_we to a non-busy register: the data is written and busy stays 0 (not an error).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-through forwarding. A read of an index being written this cycle returns the write data, using the same mem-over-ALU priority.
  - rd_busy and ld_issue_ok for an index receiving mem_we this cycle see busy=0, so a same-cycle reissue is accepted and busy stays set.
  - Zero-reg and out-of-range rules still apply.
- Undefined: reads return pre-edge state as described above.

Test Plan:
- Reset with all registers preloaded to 0xFFFF -> all rd_data=0, busy_vec=0 on the next cycle.
- alu_we idx3=0x1234 and mem_we idx3=0xBEEF in the same cycle -> reg3 reads 0xBEEF next cycle.
- Write 0xAAAA to idx0 with ZERO_REG=1 -> rd_data=0. With ZERO_REG=0 -> reads 0xAAAA.
- ld_issue idx5 -> busy_vec[5]=1 and rd_busy=1 for a port reading 5. A second ld_issue idx5 gives ld_issue_ok=0. mem_we idx5=0x0042 -> busy clears and reg5=0x0042.
- Same cycle: ld_issue idx7 and mem_we idx2 with reg2 busy -> busy[7]=1, busy[2]=0.
- NUM_REGS=12: ld_issue idx13 gives ld_issue_ok=0; write to idx13 is ignored and reads return 0. With REGFILE_BYPASS_EN, same-cycle alu_we idx4=0x5555 gives rd_data=0x5555 combinationally.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with per-register load scoreboard.
// Optional macro REGFILE_BYPASS_EN enables same-cycle write-through forwarding.
module regfile_scoreboard #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*IDX_W-1:0]    rd_idx,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       alu_we,
  input  logic [IDX_W-1:0]           alu_idx,
  input  logic [DATA_W-1:0]          alu_data,
  input  logic                       mem_we,
  input  logic [IDX_W-1:0]           mem_idx,
  input  logic [DATA_W-1:0]          mem_data,
  input  logic [IDX_W-1:0]           st_idx,
  output logic [DATA_W-1:0]          st_data,
  input  logic                       ld_issue,
  input  logic [IDX_W-1:0]           ld_issue_idx,
  output logic                       ld_issue_ok,
  output logic [NUM_REGS-1:0]        busy_vec
);

  // Storage covers the full index space; entries past NUM_REGS are never written.
  localparam int unsigned DEPTH = 32'd1 << IDX_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic              mem_wr;
  logic              alu_wr;
  logic              issue_set;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < NUM_REGS;
  endfunction

  function automatic logic writable(input logic [IDX_W-1:0] idx);
    return in_range(idx) && !(ZERO_REG != 0 && idx == '0);
  endfunction

  // Load data wins a same-index collision with the ALU.
  assign mem_wr = mem_we && writable(mem_idx);
  assign alu_wr = alu_we && writable(alu_idx) && !(mem_we && mem_idx == alu_idx);

  function automatic logic [DATA_W-1:0] read_val(input logic [IDX_W-1:0] idx);
    logic [DATA_W-1:0] v;
    v = regs_q[idx];
`ifdef REGFILE_BYPASS_EN
    if (alu_wr && alu_idx == idx) v = alu_data;
    if (mem_wr && mem_idx == idx) v = mem_data;
`endif
    if (!writable(idx)) v = '0;
    return v;
  endfunction

  function automatic logic busy_of(input logic [IDX_W-1:0] idx);
    logic b;
    b = busy_q[idx];
`ifdef REGFILE_BYPASS_EN
    if (mem_wr && mem_idx == idx) b = 1'b0;
`endif
    if (!in_range(idx)) b = 1'b0;
    return b;
  endfunction

  // Combinational read ports
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = read_val(rd_idx[k*IDX_W +: IDX_W]);
      rd_busy[k]                  = busy_of(rd_idx[k*IDX_W +: IDX_W]);
    end
  end

  assign st_data     = read_val(st_idx);
  assign ld_issue_ok = ld_issue && !rst && in_range(ld_issue_idx) && !busy_of(ld_issue_idx);
  assign issue_set   = ld_issue_ok && writable(ld_issue_idx);
  assign busy_vec    = busy_q[NUM_REGS-1:0];

  // Clear from load writeback first, then set from an accepted issue.
  always_comb begin
    busy_d = busy_q;
    if (mem_wr)    busy_d[mem_idx]      = 1'b0;
    if (issue_set) busy_d[ld_issue_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      if (alu_wr) regs_q[alu_idx] <= alu_data;
      if (mem_wr) regs_q[mem_idx] <= mem_data;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default instance plus a 12-register, no-zero-reg instance.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rd_idx;
  logic        alu_we, mem_we, ld_issue;
  logic [3:0]  alu_idx, mem_idx, st_idx, ld_issue_idx;
  logic [15:0] alu_data, mem_data;

  logic [31:0] rd_data0, rd_data1;
  logic [1:0]  rd_busy0, rd_busy1;
  logic [15:0] st_data0, st_data1;
  logic        ok0, ok1;
  logic [15:0] busy_vec0;
  logic [11:0] busy_vec1;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: index 0 = 16 regs with zero reg, index 1 = 12 regs without
  logic [15:0] mreg  [2][16];
  logic        mbusy [2][16];
  int          nregs [2] = '{16, 12};
  bit          zreg  [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_scoreboard u_dut0 (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data0), .rd_busy(rd_busy0),
    .alu_we(alu_we), .alu_idx(alu_idx), .alu_data(alu_data),
    .mem_we(mem_we), .mem_idx(mem_idx), .mem_data(mem_data),
    .st_idx(st_idx), .st_data(st_data0),
    .ld_issue(ld_issue), .ld_issue_idx(ld_issue_idx), .ld_issue_ok(ok0),
    .busy_vec(busy_vec0)
  );

  regfile_scoreboard #(.NUM_REGS(12), .ZERO_REG(0)) u_dut1 (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data1), .rd_busy(rd_busy1),
    .alu_we(alu_we), .alu_idx(alu_idx), .alu_data(alu_data),
    .mem_we(mem_we), .mem_idx(mem_idx), .mem_data(mem_data),
    .st_idx(st_idx), .st_data(st_data1),
    .ld_issue(ld_issue), .ld_issue_idx(ld_issue_idx), .ld_issue_ok(ok1),
    .busy_vec(busy_vec1)
  );

  function automatic bit m_wr(int u, int idx);
    return idx < nregs[u] && !(zreg[u] && idx == 0);
  endfunction

  function automatic logic [15:0] m_read(int u, int idx);
    if (!m_wr(u, idx)) return 16'h0;
`ifdef REGFILE_BYPASS_EN
    if (mem_we && int'(mem_idx) == idx) return mem_data;
    if (alu_we && int'(alu_idx) == idx) return alu_data;
`endif
    return mreg[u][idx];
  endfunction

  function automatic bit m_busy(int u, int idx);
    if (idx >= nregs[u]) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (mem_we && int'(mem_idx) == idx) return 1'b0;
`endif
    return mbusy[u][idx];
  endfunction

  function automatic bit m_ok(int u);
    return ld_issue && !rst && int'(ld_issue_idx) < nregs[u] && !m_busy(u, int'(ld_issue_idx));
  endfunction

  task automatic m_step(int u);
    bit ok;
    ok = m_ok(u);
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        mreg[u][i]  = 16'h0;
        mbusy[u][i] = 1'b0;
      end
    end else begin
      if (alu_we && m_wr(u, int'(alu_idx)) && !(mem_we && mem_idx == alu_idx))
        mreg[u][alu_idx] = alu_data;
      if (mem_we && m_wr(u, int'(mem_idx))) begin
        mreg[u][mem_idx]  = mem_data;
        mbusy[u][mem_idx] = 1'b0;
      end
      if (ok && m_wr(u, int'(ld_issue_idx))) mbusy[u][ld_issue_idx] = 1'b1;
    end
  endtask

  task automatic step();
    m_step(0);
    m_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; alu_we = 0; mem_we = 0; ld_issue = 0;
  endtask

  task automatic test_reset();
    idle();
    for (int i = 1; i < 16; i++) begin
      alu_we = 1; alu_idx = 4'(i); alu_data = 16'hFFFF;
      step();
    end
    alu_we = 0; ld_issue = 1; ld_issue_idx = 4'd9;
    step();
    rst = 1; alu_we = 1; alu_idx = 4'd3; ld_issue_idx = 4'd4;
    step();
    idle();
    for (int i = 0; i < 16; i++) begin
      rd_idx = {4'd0, 4'(i)};
      #1;
      vectors++;
      if (rd_data0[15:0] !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_rd idx%0d got %h want 0000", i, rd_data0[15:0]);
      end
    end
    vectors++;
    if (busy_vec0 !== 16'h0 || busy_vec1 !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_busy got %h/%h want 0", busy_vec0, busy_vec1);
    end
  endtask

  task automatic test_collision();
    idle();
    alu_we = 1; alu_idx = 4'd3; alu_data = 16'h1234;
    mem_we = 1; mem_idx = 4'd3; mem_data = 16'hBEEF;
    step();
    idle();
    rd_idx = {4'd3, 4'd0}; st_idx = 4'd3;
    #1;
    vectors++;
    if (rd_data0[31:16] !== 16'hBEEF || rd_data1[31:16] !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL collision_rd got %h/%h want beef", rd_data0[31:16], rd_data1[31:16]);
    end
    vectors++;
    if (st_data0 !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL collision_st got %h want beef", st_data0);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    alu_we = 1; alu_idx = 4'd0; alu_data = 16'hAAAA;
    step();
    idle();
    rd_idx = 8'h00; st_idx = 4'd0;
    #1;
    vectors++;
    if (rd_data0[15:0] !== 16'h0 || st_data0 !== 16'h0) begin
      miscompares++;
      $display("FAIL zero_reg_on got %h/%h want 0000", rd_data0[15:0], st_data0);
    end
    vectors++;
    if (rd_data1[15:0] !== 16'hAAAA) begin
      miscompares++;
      $display("FAIL zero_reg_off got %h want aaaa", rd_data1[15:0]);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    ld_issue = 1; ld_issue_idx = 4'd5;
    #1;
    vectors++;
    if (ok0 !== 1'b1) begin
      miscompares++;
      $display("FAIL issue5_ok got %b want 1", ok0);
    end
    step();
    rd_idx = {4'd5, 4'd1};
    #1;
    vectors++;
    if (busy_vec0[5] !== 1'b1 || rd_busy0 !== 2'b10) begin
      miscompares++;
      $display("FAIL issue5_busy got %b/%b want 1/10", busy_vec0[5], rd_busy0);
    end
    vectors++;
    if (ok0 !== 1'b0) begin
      miscompares++;
      $display("FAIL reissue5_ok got %b want 0", ok0);
    end
    idle();
    mem_we = 1; mem_idx = 4'd5; mem_data = 16'h0042;
    step();
    idle();
    #1;
    vectors++;
    if (busy_vec0[5] !== 1'b0 || rd_data0[31:16] !== 16'h0042) begin
      miscompares++;
      $display("FAIL load5 got busy %b data %h want 0 0042", busy_vec0[5], rd_data0[31:16]);
    end
  endtask

  task automatic test_issue_and_clear();
    bit exp;
`ifdef REGFILE_BYPASS_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    idle();
    ld_issue = 1; ld_issue_idx = 4'd2;
    step();
    ld_issue_idx = 4'd7; mem_we = 1; mem_idx = 4'd2; mem_data = 16'h2222;
    step();
    idle();
    #1;
    vectors++;
    if (busy_vec0[7] !== 1'b1 || busy_vec0[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL issue7_clear2 got b7=%b b2=%b want 1 0", busy_vec0[7], busy_vec0[2]);
    end
    ld_issue = 1; ld_issue_idx = 4'd7; mem_we = 1; mem_idx = 4'd7; mem_data = 16'h7070;
    #1;
    vectors++;
    if (ok0 !== exp) begin
      miscompares++;
      $display("FAIL same_idx_ok got %b want %b", ok0, exp);
    end
    step();
    idle();
    #1;
    vectors++;
    if (busy_vec0[7] !== exp) begin
      miscompares++;
      $display("FAIL same_idx_busy got %b want %b", busy_vec0[7], exp);
    end
  endtask

  task automatic test_out_of_range();
    idle();
    ld_issue = 1; ld_issue_idx = 4'd13;
    alu_we = 1; alu_idx = 4'd13; alu_data = 16'h7777;
    #1;
    vectors++;
    if (ok1 !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_issue_ok got %b want 0", ok1);
    end
    step();
    idle();
    rd_idx = {4'd0, 4'd13};
    #1;
    vectors++;
    if (rd_data1[15:0] !== 16'h0 || rd_busy1[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_read got %h busy %b want 0000 0", rd_data1[15:0], rd_busy1[0]);
    end
    vectors++;
    if (rd_data0[15:0] !== 16'h7777 || rd_busy0[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL idx13_full got %h busy %b want 7777 1", rd_data0[15:0], rd_busy0[0]);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp;
    idle();
    alu_we = 1; alu_idx = 4'd4; alu_data = 16'h5555;
    rd_idx = {4'd0, 4'd4};
`ifdef REGFILE_BYPASS_EN
    exp = 16'h5555;
`else
    exp = mreg[0][4];
`endif
    #1;
    vectors++;
    if (rd_data0[15:0] !== exp) begin
      miscompares++;
      $display("FAIL bypass_same_cycle got %h want %h", rd_data0[15:0], exp);
    end
    step();
    idle();
    #1;
    vectors++;
    if (rd_data0[15:0] !== 16'h5555) begin
      miscompares++;
      $display("FAIL bypass_next_cycle got %h want 5555", rd_data0[15:0]);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_rd0, e_rd1;
    logic [1:0]  e_b0, e_b1;
    logic [15:0] e_bv0;
    logic [11:0] e_bv1;
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      rd_idx       = 8'($urandom);
      st_idx       = 4'($urandom);
      alu_we       = 1'($urandom);
      alu_idx      = 4'($urandom);
      alu_data     = 16'($urandom);
      mem_we       = 1'($urandom);
      mem_idx      = ($urandom_range(0, 1) == 0) ? alu_idx : 4'($urandom);
      mem_data     = 16'($urandom);
      ld_issue     = 1'($urandom);
      ld_issue_idx = ($urandom_range(0, 3) == 0) ? mem_idx : 4'($urandom);
      #1;
      for (int k = 0; k < 2; k++) begin
        e_rd0[k*16 +: 16] = m_read(0, int'(rd_idx[k*4 +: 4]));
        e_rd1[k*16 +: 16] = m_read(1, int'(rd_idx[k*4 +: 4]));
        e_b0[k]           = m_busy(0, int'(rd_idx[k*4 +: 4]));
        e_b1[k]           = m_busy(1, int'(rd_idx[k*4 +: 4]));
      end
      for (int i = 0; i < 16; i++) e_bv0[i] = mbusy[0][i];
      for (int i = 0; i < 12; i++) e_bv1[i] = mbusy[1][i];
      vectors++;
      if (rd_data0 !== e_rd0 || rd_data1 !== e_rd1) begin
        miscompares++;
        $display("FAIL rand_rd cyc%0d got %h/%h want %h/%h", n, rd_data0, rd_data1, e_rd0, e_rd1);
      end
      vectors++;
      if (rd_busy0 !== e_b0 || rd_busy1 !== e_b1) begin
        miscompares++;
        $display("FAIL rand_rd_busy cyc%0d got %b/%b want %b/%b", n, rd_busy0, rd_busy1, e_b0, e_b1);
      end
      vectors++;
      if (st_data0 !== m_read(0, int'(st_idx)) || st_data1 !== m_read(1, int'(st_idx))) begin
        miscompares++;
        $display("FAIL rand_st cyc%0d got %h/%h want %h/%h", n, st_data0, st_data1,
                 m_read(0, int'(st_idx)), m_read(1, int'(st_idx)));
      end
      vectors++;
      if (ok0 !== m_ok(0) || ok1 !== m_ok(1)) begin
        miscompares++;
        $display("FAIL rand_issue_ok cyc%0d got %b/%b want %b/%b", n, ok0, ok1, m_ok(0), m_ok(1));
      end
      vectors++;
      if (busy_vec0 !== e_bv0 || busy_vec1 !== e_bv1) begin
        miscompares++;
        $display("FAIL rand_busy_vec cyc%0d got %h/%h want %h/%h", n, busy_vec0, busy_vec1, e_bv0, e_bv1);
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1; rd_idx = '0; st_idx = '0; alu_idx = '0; mem_idx = '0; ld_issue_idx = '0;
    alu_data = '0; mem_data = '0;
    step();
    step();
    test_reset();
    test_collision();
    test_zero_reg();
    test_scoreboard();
    test_issue_and_clear();
    test_out_of_range();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
